// File: rtl/aes_key_schedule.sv
// AES-128 key expansion: computes one round key per cycle into 11 slots and
// serves any slot through a registered read port indexed by rd_idx.
module aes_key_schedule (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [3:0]   rd_idx,
  output logic [127:0] round_key,
  output logic         busy,
  output logic         valid,
  output logic         done
);

  localparam int unsigned KW    = 128;
  localparam int unsigned WW    = 32;
  localparam int unsigned CW    = 4;
  localparam int unsigned NSLOT = 11;
  localparam logic [CW-1:0] LAST_IDX = CW'(NSLOT - 1);

  // Standard AES forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_e;

  // Byte b lives at bit offset (255-b)*8, i.e. {~b, 3'b000}.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [CW-1:0] idx);
    logic [7:0] r;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic [KW-1:0]   round_key_q;
  logic [KW-1:0]   slot_q [NSLOT];

  logic            wr_en_c;
  logic [CW-1:0]   wr_idx_c;
  logic [KW-1:0]   wr_data_c;
  logic [CW-1:0]   prev_idx_c;
  logic [KW-1:0]   prev_c;
  logic [WW-1:0]   rot_c, sub_c, t_c;
  logic [WW-1:0]   w0_c, w1_c, w2_c, w3_c;
  logic [KW-1:0]   expand_c;
  logic [KW-1:0]   rd_c;

  // One FIPS-197 round of the key schedule applied to the previous slot.
  always_comb begin
    prev_idx_c = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
    prev_c     = slot_q[prev_idx_c];
    rot_c      = {prev_c[23:0], prev_c[31:24]};
  end

  for (genvar g = 0; g < 4; g++) begin : g_sub
    assign sub_c[8*g +: 8] = sbox(rot_c[8*g +: 8]);
  end

  always_comb begin
    t_c      = sub_c ^ {rcon(cnt_q), 24'h000000};
    w0_c     = prev_c[127:96] ^ t_c;
    w1_c     = prev_c[95:64]  ^ w0_c;
    w2_c     = prev_c[63:32]  ^ w1_c;
    w3_c     = prev_c[31:0]   ^ w2_c;
    expand_c = {w0_c, w1_c, w2_c, w3_c};
  end

  always_comb begin
    rd_c = (rd_idx <= LAST_IDX) ? slot_q[rd_idx] : '0;
  end

  // Next-state, slot write control and flag updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    valid_d   = valid_q;
    done_d    = 1'b0;
    wr_en_c   = 1'b0;
    wr_idx_c  = cnt_q;
    wr_data_c = expand_c;
    case (state_q)
      IDLE, READY: begin
        if (start) begin
          state_d   = EXPAND;
          cnt_d     = CW'(1);
          busy_d    = 1'b1;
          valid_d   = 1'b0;
          wr_en_c   = 1'b1;
          wr_idx_c  = '0;
          wr_data_c = key;
        end
      end
      EXPAND: begin
        wr_en_c = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = READY;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      round_key_q <= '0;
      for (int i = 0; i < int'(NSLOT); i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      round_key_q <= rd_c;
      if (wr_en_c) begin
        slot_q[wr_idx_c] <= wr_data_c;
      end
    end
  end

  assign round_key = round_key_q;
  assign busy      = busy_q;
  assign valid     = valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: word-level FIPS-197 reference with a GF(2^8)
// derived S-box, per-cycle output comparison and directed literal checks.
module tb_aes_key_schedule;

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [127:0] key;
  logic [3:0]   rd_idx;
  logic [127:0] round_key;
  logic         busy, valid, done;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sbox_tab [256];

  aes_key_schedule dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .key      (key),
    .rd_idx   (rd_idx),
    .round_key(round_key),
    .busy     (busy),
    .valid    (valid),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Textbook word-by-word expansion w[0..43]; returns round key idx.
  function automatic logic [127:0] rk_of(input logic [127:0] k, input int idx);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  // Reference behaviour: slot j holds round key j of the accepted key from
  // the j-th edge after acceptance; reads show the pre-edge slot contents.
  logic [127:0] m_slot [11];
  logic [127:0] m_keys [11];
  logic [127:0] m_rk = '0;
  logic         m_busy = 1'b0, m_valid = 1'b0, m_done = 1'b0, m_run = 1'b0;
  int           m_age = 0;

  always @(posedge clk or negedge reset_n) begin
    logic [127:0] nrk;
    if (!reset_n) begin
      for (int j = 0; j < 11; j++) m_slot[j] = '0;
      m_rk = '0; m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_run = 1'b0; m_age = 0;
    end else begin
      nrk = (rd_idx <= 4'd10) ? m_slot[rd_idx] : '0;
      m_done = 1'b0;
      if (m_run) begin
        m_age++;
        m_slot[m_age] = m_keys[m_age];
        if (m_age == 10) begin
          m_run = 1'b0; m_busy = 1'b0; m_valid = 1'b1; m_done = 1'b1;
        end
      end else if (start) begin
        for (int j = 0; j < 11; j++) m_keys[j] = rk_of(key, j);
        m_slot[0] = key;
        m_age = 0; m_run = 1'b1; m_busy = 1'b1; m_valid = 1'b0;
      end
      m_rk = nrk;
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy",  {127'd0, busy},  {127'd0, m_busy});
    chk("cyc_valid", {127'd0, valid}, {127'd0, m_valid});
    chk("cyc_done",  {127'd0, done},  {127'd0, m_done});
    chk("cyc_round_key", round_key, m_rk);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b(input string nm, input logic act, input logic exp);
    chk(nm, {127'd0, act}, {127'd0, exp});
  endtask

  initial begin
    start = 1'b0; key = '0; rd_idx = '0; reset_n = 1'b1;
    build_sbox();
    chk("pin_sbox_00", {120'd0, sbox_tab[8'h00]}, {120'd0, 8'h63});
    chk("pin_sbox_53", {120'd0, sbox_tab[8'h53]}, {120'd0, 8'hed});
    chk("pin_k1_r1",  rk_of(K1, 1),  K1_R1);
    chk("pin_k1_r10", rk_of(K1, 10), K1_R10);
    chk("pin_k2_r10", rk_of(K2, 10), K2_R10);
    #1 reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_round_key", round_key, '0);
    b("rst_busy", busy, 1'b0);

    // Start while in reset is ignored.
    start = 1'b1; key = K1;
    tick();
    start = 1'b0;
    tick();
    b("rst_start_busy", busy, 1'b0);
    reset_n = 1'b1;
    tick();

    // FIPS-197 expansion and completion timing.
    start = 1'b1; key = K1;
    tick();
    start = 1'b0; key = K2;
    b("exp_busy_k", busy, 1'b1);
    b("exp_valid_k", valid, 1'b0);
    repeat (9) tick();
    b("exp_done_k9", done, 1'b0);
    b("exp_busy_k9", busy, 1'b1);
    tick();
    b("exp_done_k10", done, 1'b1);
    b("exp_valid_k10", valid, 1'b1);
    b("exp_busy_k10", busy, 1'b0);
    tick();
    b("exp_done_k11", done, 1'b0);
    rd_idx = 4'd1;  tick(); chk("rd_r1", round_key, K1_R1);
    rd_idx = 4'd10; tick(); chk("rd_r10", round_key, K1_R10);
    rd_idx = 4'd0;  tick(); chk("rd_r0", round_key, K1);

    // Reverse-order sweep with one-cycle read latency.
    for (int i = 10; i >= 0; i--) begin
      rd_idx = 4'(i);
      tick();
      chk("rev_sweep", round_key, rk_of(K1, i));
    end
    rd_idx = 4'd12; tick(); chk("rd_oob", round_key, '0);

    // Start pulsed during expansion is ignored.
    start = 1'b1; key = K1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    start = 1'b1; key = K2;
    tick();
    start = 1'b0;
    b("ign_busy_k4", busy, 1'b1);
    repeat (5) tick();
    b("ign_done_k9", done, 1'b0);
    tick();
    b("ign_done_k10", done, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      b("ign_done_after", done, 1'b0);
    end
    rd_idx = 4'd10; tick(); chk("ign_r10", round_key, K1_R10);
    rd_idx = 4'd0;  tick(); chk("ign_r0", round_key, K1);

    // Restart from READY with a second key.
    start = 1'b1; key = K2;
    tick();
    start = 1'b0;
    b("rs_valid_k", valid, 1'b0);
    b("rs_busy_k", busy, 1'b1);
    repeat (9) tick();
    b("rs_done_k9", done, 1'b0);
    tick();
    b("rs_done_k10", done, 1'b1);
    rd_idx = 4'd10; tick(); chk("rs_r10", round_key, K2_R10);

    // Reset mid-expansion, then start on the first edge after release.
    start = 1'b1; key = K1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2 reset_n = 1'b0;
    #1;
    b("ar_busy", busy, 1'b0);
    b("ar_valid", valid, 1'b0);
    b("ar_done", done, 1'b0);
    chk("ar_round_key", round_key, '0);
    tick();
    reset_n = 1'b1; start = 1'b1; key = K1; rd_idx = 4'd5;
    tick();
    start = 1'b0;
    chk("ar_slot5_cleared", round_key, '0);
    b("ar_busy_first", busy, 1'b1);
    repeat (9) tick();
    b("ar_done_k9", done, 1'b0);
    tick();
    b("ar_done_k10", done, 1'b1);
    rd_idx = 4'd10; tick(); chk("ar_r10", round_key, K1_R10);
    rd_idx = 4'd3;  tick(); chk("ar_r3", round_key, rk_of(K1, 3));
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_key_schedule.md
AES_KEY_SCHEDULE -- requirements
Module: aes_key_schedule

Interface
REQ-001 The block SHALL have no parameters; AES-128 only (Nk=4, Nr=10, 11 round keys).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to expand key; honoured only when not busy.
REQ-005 key  input  128  cipher key; byte 0 at [127:120], byte 15 at [7:0]; sampled on the accepted start edge only.
REQ-006 rd_idx  input  4  round-key index to read, 0..10.
REQ-007 round_key  output  128  registered round key for the rd_idx presented one edge earlier.
REQ-008 busy  output  1  high while expansion is in progress.
REQ-009 valid  output  1  high when all 11 stored keys belong to the last accepted key.
REQ-010 done  output  1  one-cycle pulse on expansion completion.

Function
REQ-011 FSM states SHALL be exactly IDLE, EXPAND and READY.
- IDLE or READY with start=1 -> EXPAND.
- EXPAND with cnt=10 -> READY.
REQ-012 On the accepted start edge (edge k), the block SHALL write key to slot 0, set cnt=1, clear valid and set busy.
REQ-013 On edges k+1..k+10, the block SHALL write slot cnt = expand(slot cnt-1, Rcon[cnt]) and increment cnt; exactly one round key per cycle.
REQ-014 expand SHALL follow FIPS-197.
- w3' = SubWord(RotWord(w3)) xor {Rcon,00,00,00}.
- Then w0^=w3', w1^=w0, w2^=w1, w3^=w2, chained within the same cycle.
- Words are w0=[127:96] through w3=[31:0].
REQ-015 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36; the S-box SHALL be the standard AES forward S-box, combinational, four instances.
REQ-016 At edge k+10 the block SHALL enter READY, set valid=1, clear busy, and assert done for exactly the following cycle.
REQ-017 start while busy=1 SHALL be ignored; no restart and no effect on cnt or slots.
REQ-018 start in READY SHALL restart expansion per REQ-012; valid falls at that edge; prior keys are overwritten progressively.
REQ-019 round_key SHALL update every edge from slot[rd_idx] regardless of state; rd_idx 11..15 SHALL yield 128'h0.
REQ-020 Reads during EXPAND SHALL return current slot contents; such reads are undefined for the user, and valid=0 flags this.
REQ-021 Reverse order (10 down to 0) for the downstream decryption round sequencer SHALL be supported purely through rd_idx; no internal read ordering.
REQ-022 start and reset_n deasserted in the same cycle SHALL result in reset taking precedence.

Reset
REQ-023 While reset_n=0, the block SHALL hold state=IDLE, cnt=0, all 11 slots=0, round_key=0, busy=0, valid=0, done=0.
REQ-024 Reset asserted mid-EXPAND SHALL abort immediately to the REQ-023 values; no partial keys remain.
REQ-025 After reset release, the block SHALL accept a start on the first rising edge.

Verification
REQ-026 FIPS-197 vector: key=2b7e151628aed2a6abf7158809cf4f3c, start at edge k.
- done high only in the cycle after edge k+10; busy high from k to k+10.
- rd_idx=1 -> a0fafe1788542cb123a339392a6c7605.
- rd_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- rd_idx=0 -> the input key.
REQ-027 Read latency: after READY, step rd_idx 10,9,...,0 one per cycle; round_key matches each index exactly one cycle later; rd_idx=12 -> 0.
REQ-028 start pulsed at k+4 during EXPAND -> ignored; results identical to REQ-026, and done occurs once at the original time.
REQ-029 Restart from READY with key=000102030405060708090a0b0c0d0e0f -> valid drops at the start edge.
- Slot 10 = 13111d7fe3944a17f307a78b4d2b30c5 after 10 cycles.
- done pulses again.
REQ-030 Reset_n pulsed low at k+5 -> all outputs and slots zero at once, state IDLE; a new start after release expands correctly per REQ-026.
